seg7_scan_decoder: RTL and testbench



---
 rtl/seg7_scan_decoder.sv | 267 ++++++++++++++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: passive monitor on a multiplexed 7-segment bus.
// Recovers the 5-bit symbol code per digit, keeps a per-digit register file,
// emits change updates on a valid/ready stream and flags illegal bus states.
// Optional feature: define SEG7_STALE_TIMEOUT_EN to add per-digit refresh
// timeouts that drop digit_valid when a digit stops being scanned.
module seg7_scan_decoder #(
  parameter int unsigned DIGITS        = 4,
  parameter int unsigned STABLE_CYCLES = 8,
  parameter int unsigned STALE_CYCLES  = 65535,
  localparam int unsigned UW = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [6:0]          seg_in,
  input  logic [DIGITS-1:0]   an_in,
  output logic [5*DIGITS-1:0] code_out,
  output logic [DIGITS-1:0]   digit_valid,
  output logic                upd_valid,
  input  logic                upd_ready,
  output logic [UW-1:0]       upd_digit,
  output logic [4:0]          upd_code,
  output logic                err_unknown,
  output logic                err_anode,
  output logic                upd_ovf,
  input  logic                clr_err
);

  localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StTrack, StLocked} state_e;

  state_e state_q, state_d;

  logic [6:0]        seg_s_q;
  logic [DIGITS-1:0] an_s_q;
  logic [6:0]        lat_seg_q, lat_seg_d;
  logic [DIGITS-1:0] lat_an_q, lat_an_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic [DIGITS-1:0][4:0] code_q, code_d;
  logic [DIGITS-1:0]      valid_q, valid_d;

  logic          upd_valid_q, upd_valid_d;
  logic [UW-1:0] upd_digit_q, upd_digit_d;
  logic [4:0]    upd_code_q, upd_code_d;
  logic          err_unknown_q, err_unknown_d;
  logic          err_anode_q, err_anode_d;
  logic          upd_ovf_q, upd_ovf_d;

  logic [3:0]    low_cnt;
  logic          one_hot, multi_hot, same;
  logic          capture, restart, anode_set, new_upd, ovf_set;
  logic [UW-1:0] cap_idx;
  logic [5:0]    cap_dec;
  logic [4:0]    cap_code;
  logic          cap_unk;

  // Segment pattern to {unknown, code}; first listed pattern wins.
  function automatic logic [5:0] decode_seg(input logic [6:0] p);
    logic [5:0] r;
    r = {1'b1, 5'd31};
    case (p)
      7'b0001110: r = {1'b0, 5'd0};
      7'b0000110: r = {1'b0, 5'd1};
      7'b1000111: r = {1'b0, 5'd2};
      7'b1001111: r = {1'b0, 5'd3};
      7'b0100100: r = {1'b0, 5'd4};
      7'b1001000: r = {1'b0, 5'd5};
      7'b1000001: r = {1'b0, 5'd6};
      7'b0000111: r = {1'b0, 5'd7};
      7'b1001110: r = {1'b0, 5'd8};
      7'b1000000: r = {1'b0, 5'd9};
      7'b0001001: r = {1'b0, 5'd10};
      7'b0001000: r = {1'b0, 5'd11};
      7'b1001100: r = {1'b0, 5'd12};
      7'b0000011: r = {1'b0, 5'd13};
      7'b0100001: r = {1'b0, 5'd14};
      7'b0010010: r = {1'b0, 5'd15};
      7'b1000110: r = {1'b0, 5'd16};
      7'b1011000: r = {1'b0, 5'd17};
      7'b0110000: r = {1'b0, 5'd18};
      7'b0011001: r = {1'b0, 5'd19};
      7'b0000010: r = {1'b0, 5'd21};
      7'b1111000: r = {1'b0, 5'd22};
      7'b0000000: r = {1'b0, 5'd23};
      7'b0010000: r = {1'b0, 5'd24};
      7'b0101111: r = {1'b0, 5'd26};
      7'b1111111: r = {1'b0, 5'd31};
      default:    r = {1'b1, 5'd31};
    endcase
    return r;
  endfunction

  // Classify the sampled anode vector by number of low lines.
  always_comb begin
    low_cnt = '0;
    for (int i = 0; i < DIGITS; i++) begin
      low_cnt = low_cnt + {3'b000, ~an_s_q[i]};
    end
  end

  assign one_hot   = (low_cnt == 4'd1);
  assign multi_hot = (low_cnt > 4'd1);
  assign same      = (seg_s_q == lat_seg_q) && (an_s_q == lat_an_q);

  // Digit index of the latched (one-hot-low) anode vector.
  always_comb begin
    cap_idx = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!lat_an_q[i]) cap_idx = UW'(i);
    end
  end

  assign cap_dec  = decode_seg(lat_seg_q);
  assign cap_code = cap_dec[4:0];
  assign cap_unk  = cap_dec[5];

  // Stability FSM: any change restarts tracking from the IDLE entry rules.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lat_seg_d = lat_seg_q;
    lat_an_d  = lat_an_q;
    capture   = 1'b0;
    restart   = 1'b0;
    anode_set = 1'b0;
    case (state_q)
      StIdle: restart = 1'b1;
      StTrack: begin
        if (!same) begin
          restart = 1'b1;
        end else if (cnt_q == CW'(STABLE_CYCLES - 1)) begin
          capture = 1'b1;
          cnt_d   = CW'(STABLE_CYCLES);
          state_d = StLocked;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StLocked: begin
        if (!same) restart = 1'b1;
      end
      default: state_d = StIdle;
    endcase
    if (restart) begin
      if (one_hot) begin
        state_d   = StTrack;
        cnt_d     = CW'(1);
        lat_seg_d = seg_s_q;
        lat_an_d  = an_s_q;
      end else begin
        state_d   = StIdle;
        cnt_d     = '0;
        anode_set = multi_hot;
      end
    end
  end

`ifdef SEG7_STALE_TIMEOUT_EN
  localparam int unsigned AW = $clog2(STALE_CYCLES + 1);
  logic [DIGITS-1:0][AW-1:0] age_q, age_d;
  logic [DIGITS-1:0]         stale_hit;

  // Per-digit age: cleared while the anode is low, saturates at the timeout.
  always_comb begin
    age_d     = age_q;
    stale_hit = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!an_s_q[i]) begin
        age_d[i] = '0;
      end else if (age_q[i] != AW'(STALE_CYCLES)) begin
        age_d[i] = age_q[i] + 1'b1;
        stale_hit[i] = (age_d[i] == AW'(STALE_CYCLES));
      end
    end
  end

  // Age counter registers.
  always_ff @(posedge clk) begin
    if (rst) age_q <= '0;
    else     age_q <= age_d;
  end
`endif

  // Register file, update stream and sticky flags.
  always_comb begin
    code_d      = code_q;
    valid_d     = valid_q;
    new_upd     = 1'b0;
    ovf_set     = 1'b0;
    upd_valid_d = upd_valid_q;
    upd_digit_d = upd_digit_q;
    upd_code_d  = upd_code_q;
`ifdef SEG7_STALE_TIMEOUT_EN
    valid_d = valid_q & ~stale_hit;
`endif
    if (capture) begin
      new_upd          = !valid_q[cap_idx] || (code_q[cap_idx] != cap_code);
      code_d[cap_idx]  = cap_code;
      valid_d[cap_idx] = 1'b1;
    end
    if (upd_valid_q && upd_ready) upd_valid_d = 1'b0;
    if (new_upd) begin
      // Latest wins; only a load over an unaccepted update is an overflow.
      ovf_set     = upd_valid_q && !upd_ready;
      upd_valid_d = 1'b1;
      upd_digit_d = cap_idx;
      upd_code_d  = cap_code;
    end
    // Set has priority over a simultaneous clear.
    err_unknown_d = (capture && cap_unk) || (err_unknown_q && !clr_err);
    err_anode_d   = anode_set || (err_anode_q && !clr_err);
    upd_ovf_d     = ovf_set || (upd_ovf_q && !clr_err);
  end

  // Input sample register; resets to an idle (blank) bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_s_q <= '1;
      an_s_q  <= '1;
    end else begin
      seg_s_q <= seg_in;
      an_s_q  <= an_in;
    end
  end

  // FSM, register file and stream state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      lat_seg_q     <= '1;
      lat_an_q      <= '1;
      code_q        <= '0;
      valid_q       <= '0;
      upd_valid_q   <= 1'b0;
      upd_digit_q   <= '0;
      upd_code_q    <= '0;
      err_unknown_q <= 1'b0;
      err_anode_q   <= 1'b0;
      upd_ovf_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      lat_seg_q     <= lat_seg_d;
      lat_an_q      <= lat_an_d;
      code_q        <= code_d;
      valid_q       <= valid_d;
      upd_valid_q   <= upd_valid_d;
      upd_digit_q   <= upd_digit_d;
      upd_code_q    <= upd_code_d;
      err_unknown_q <= err_unknown_d;
      err_anode_q   <= err_anode_d;
      upd_ovf_q     <= upd_ovf_d;
    end
  end

  assign code_out    = code_q;
  assign digit_valid = valid_q;
  assign upd_valid   = upd_valid_q;
  assign upd_digit   = upd_digit_q;
  assign upd_code    = upd_code_q;
  assign err_unknown = err_unknown_q;
  assign err_anode   = err_anode_q;
  assign upd_ovf     = upd_ovf_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Self-checking bench for seg7_scan_decoder: run-length reference model,
// per-cycle compare, directed scenarios plus randomized bus traffic.
module tb_seg7_scan_decoder;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned STABLE = 8;
  localparam int unsigned STALE  = 100;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  seg_in;
  logic [3:0]  an_in;
  logic [19:0] code_out;
  logic [3:0]  digit_valid;
  logic        upd_valid;
  logic        upd_ready;
  logic [1:0]  upd_digit;
  logic [4:0]  upd_code;
  logic        err_unknown;
  logic        err_anode;
  logic        upd_ovf;
  logic        clr_err;

  int checks = 0;
  int errors = 0;

  seg7_scan_decoder #(
    .DIGITS(DIGITS),
    .STABLE_CYCLES(STABLE),
    .STALE_CYCLES(STALE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .seg_in(seg_in),
    .an_in(an_in),
    .code_out(code_out),
    .digit_valid(digit_valid),
    .upd_valid(upd_valid),
    .upd_ready(upd_ready),
    .upd_digit(upd_digit),
    .upd_code(upd_code),
    .err_unknown(err_unknown),
    .err_anode(err_anode),
    .upd_ovf(upd_ovf),
    .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] PATS [26] = '{
    7'b0001110, 7'b0000110, 7'b1000111, 7'b1001111, 7'b0100100, 7'b1001000,
    7'b1000001, 7'b0000111, 7'b1001110, 7'b1000000, 7'b0001001, 7'b0001000,
    7'b1001100, 7'b0000011, 7'b0100001, 7'b0010010, 7'b1000110, 7'b1011000,
    7'b0110000, 7'b0011001, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000,
    7'b0101111, 7'b1111111};
  localparam int CODES [26] = '{
    0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 16, 17, 18, 19,
    21, 22, 23, 24, 26, 31};

  // Table lookup; -1 when the pattern is not listed.
  function automatic int ref_decode(input logic [6:0] p);
    int best = -1;
    for (int k = 0; k < 26; k++) begin
      if (PATS[k] == p && (best < 0 || CODES[k] < best)) best = CODES[k];
    end
    return best;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: a capture happens when a run of identical one-hot samples
  // reaches exactly STABLE samples.
  bit         m_live = 1'b0;
  logic [6:0] m_prev_seg, m_run_seg;
  logic [3:0] m_prev_an, m_run_an;
  int         m_run_len;
  logic [4:0] m_code [4];
  bit         m_valid [4];
  int         m_age [4];
  bit         m_uv, m_eu, m_ea, m_ovf;
  int         m_udig, m_ucode;
  int         lows, d, mcode;
  bit         cap, unk, newu;

  always @(posedge clk) begin
    if (rst) begin
      m_live = 1'b1;
      m_run_len = 0;
      for (int i = 0; i < 4; i++) begin
        m_code[i] = '0; m_valid[i] = 1'b0; m_age[i] = 0;
      end
      m_uv = 0; m_eu = 0; m_ea = 0; m_ovf = 0; m_udig = 0; m_ucode = 0;
      m_prev_seg = 7'h7f;
      m_prev_an  = 4'hf;
    end else if (m_live) begin
      lows = 0;
      d = 0;
      for (int i = 0; i < 4; i++) if (!m_prev_an[i]) begin lows++; d = i; end
      cap = 1'b0;
      if (lows == 1) begin
        if (m_run_len > 0 && m_prev_seg == m_run_seg && m_prev_an == m_run_an) begin
          m_run_len++;
        end else begin
          m_run_seg = m_prev_seg; m_run_an = m_prev_an; m_run_len = 1;
        end
        cap = (m_run_len == STABLE);
      end else begin
        m_run_len = 0;
      end
`ifdef SEG7_STALE_TIMEOUT_EN
      for (int i = 0; i < 4; i++) begin
        if (!m_prev_an[i]) m_age[i] = 0;
        else if (m_age[i] < STALE) begin
          m_age[i]++;
          if (m_age[i] == STALE) m_valid[i] = 1'b0;
        end
      end
`endif
      newu = 1'b0;
      unk  = 1'b0;
      mcode = 0;
      if (cap) begin
        mcode = ref_decode(m_prev_seg);
        unk = (mcode < 0);
        if (unk) mcode = 31;
        newu = !m_valid[d] || (m_code[d] != 5'(mcode));
        m_code[d] = 5'(mcode);
        m_valid[d] = 1'b1;
      end
      m_eu  = (cap && unk) || (m_eu && !clr_err);
      m_ea  = (lows > 1) || (m_ea && !clr_err);
      m_ovf = (newu && m_uv && !upd_ready) || (m_ovf && !clr_err);
      if (newu) begin
        m_uv = 1'b1; m_udig = d; m_ucode = mcode;
      end else if (m_uv && upd_ready) begin
        m_uv = 1'b0;
      end
      m_prev_seg = seg_in;
      m_prev_an  = an_in;
    end
  end

  // Compare all outputs against the model every cycle once reset has been seen.
  logic [19:0] ecode;
  logic [3:0]  evalid;
  always @(negedge clk) begin
    if (m_live) begin
      for (int i = 0; i < 4; i++) begin
        ecode[5*i +: 5] = m_code[i];
        evalid[i] = m_valid[i];
      end
      chk("code_out", 32'(code_out), 32'(ecode));
      chk("digit_valid", 32'(digit_valid), 32'(evalid));
      chk("upd_valid", 32'(upd_valid), 32'(m_uv));
      chk("upd_digit", 32'(upd_digit), 32'(m_udig));
      chk("upd_code", 32'(upd_code), 32'(m_ucode));
      chk("err_unknown", 32'(err_unknown), 32'(m_eu));
      chk("err_anode", 32'(err_anode), 32'(m_ea));
      chk("upd_ovf", 32'(upd_ovf), 32'(m_ovf));
    end
  end

  // Record accepted updates as {digit, code}.
  logic [6:0] xfers [$];
  always @(posedge clk) begin
    if (!rst && upd_valid === 1'b1 && upd_ready === 1'b1) xfers.push_back({upd_digit, upd_code});
  end

  task automatic drive(input logic [3:0] an, input logic [6:0] seg, input int n);
    repeat (n) begin
      @(negedge clk);
      an_in = an;
      seg_in = seg;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; an_in = 4'hf; seg_in = 7'h7f; clr_err = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  bit         idle_uv;
  int         nx, seg_len, kind, dig;
  logic [3:0] ran;
  logic [6:0] rseg;
  logic [6:0] last_x;

  initial begin
    rst = 1'b1; an_in = 4'hf; seg_in = 7'h7f; upd_ready = 1'b1; clr_err = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Idle bus after reset.
    idle_uv = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (upd_valid !== 1'b0) idle_uv = 1'b1;
    end
    chk("idle_upd_valid_seen", 32'(idle_uv), 0);
    chk("idle_code_out", 32'(code_out), 0);
    chk("idle_flags_valid", 32'({err_unknown, err_anode, upd_ovf, digit_valid}), 0);

    // Two-digit scan.
    xfers.delete();
    drive(4'b1110, 7'b0001110, 20);
    drive(4'b1101, 7'b1000000, 20);
    drive(4'b1111, 7'h7f, 3);
    chk("scan_n_updates", 32'(xfers.size()), 2);
    if (xfers.size() >= 2) begin
      chk("scan_upd0", 32'(xfers[0]), 32'({2'd0, 5'd0}));
      chk("scan_upd1", 32'(xfers[1]), 32'({2'd1, 5'd9}));
    end
    chk("scan_code_lo", 32'(code_out[9:0]), 32'({5'd9, 5'd0}));
    chk("scan_digit_valid", 32'(digit_valid), 32'(4'b0011));

    // Stability threshold boundary.
    do_reset();
    drive(4'b1110, 7'b0001110, 7);
    drive(4'b1111, 7'h7f, 5);
    chk("hold7_no_capture", 32'(digit_valid), 0);
    drive(4'b1110, 7'b0001110, 8);
    @(negedge clk);
    chk("hold8_before_edge9", 32'(digit_valid), 0);
    an_in = 4'hf; seg_in = 7'h7f;
    @(negedge clk);
    chk("hold8_at_edge9", 32'(digit_valid), 32'(4'b0001));

    // Code changes and unknown pattern on digit 2.
    drive(4'b1011, 7'b0010010, 12);
    chk("d2_code15", 32'(code_out[14:10]), 15);
    drive(4'b1011, 7'b0000111, 12);
    chk("d2_code7", 32'(code_out[14:10]), 7);
    drive(4'b1011, 7'b1010101, 12);
    chk("d2_code31", 32'(code_out[14:10]), 31);
    chk("d2_err_unknown", 32'(err_unknown), 1);
    @(negedge clk); clr_err = 1'b1;
    @(negedge clk); clr_err = 1'b0;
    @(negedge clk);
    chk("clr_err_unknown", 32'(err_unknown), 0);

    // Backpressure overflow and multi-hot anodes.
    do_reset();
    upd_ready = 1'b0;
    drive(4'b1110, 7'b0100100, 12);
    drive(4'b1101, 7'b1001000, 12);
    chk("bp_upd_valid", 32'(upd_valid), 1);
    chk("bp_upd_digit", 32'(upd_digit), 1);
    chk("bp_upd_code", 32'(upd_code), 5);
    chk("bp_upd_ovf", 32'(upd_ovf), 1);
    drive(4'b1100, 7'b1000000, 12);
    chk("multi_err_anode", 32'(err_anode), 1);
    chk("multi_no_capture", 32'(digit_valid), 32'(4'b0011));
    upd_ready = 1'b1;
    drive(4'b1111, 7'h7f, 3);

`ifdef SEG7_STALE_TIMEOUT_EN
    // Digit 0 goes stale, then re-scanning the same code emits an update.
    do_reset();
    drive(4'b1110, 7'b1000000, 12);
    drive(4'b1101, 7'b0000110, STALE + 10);
    chk("stale_valid0", 32'(digit_valid[0]), 0);
    chk("stale_code_kept", 32'(code_out[4:0]), 9);
    nx = xfers.size();
    drive(4'b1110, 7'b1000000, 12);
    chk("stale_reupd_count", 32'(xfers.size()), 32'(nx + 1));
    if (xfers.size() > 0) begin
      last_x = xfers[xfers.size() - 1];
      chk("stale_reupd", 32'(last_x), 32'({2'd0, 5'd9}));
    end
`endif

    // Randomized bus traffic.
    do_reset();
    for (int s = 0; s < 300; s++) begin
      if ($urandom_range(0, 39) == 0) do_reset();
      kind = int'($urandom_range(0, 9));
      if (kind == 0) begin
        ran = 4'hf;
      end else if (kind == 1) begin
        ran = 4'($urandom_range(0, 15));
        while ((!ran[0] + !ran[1] + !ran[2] + !ran[3]) < 2) ran = 4'($urandom_range(0, 15));
      end else begin
        dig = int'($urandom_range(0, 3));
        ran = 4'hf;
        ran[dig] = 1'b0;
      end
      case ($urandom_range(0, 9))
        0:       rseg = 7'h7f;
        1, 2:    rseg = 7'($urandom_range(0, 127));
        default: rseg = PATS[$urandom_range(0, 25)];
      endcase
      seg_len = int'($urandom_range(1, 14));
      repeat (seg_len) begin
        @(negedge clk);
        an_in = ran;
        seg_in = rseg;
        upd_ready = ($urandom_range(0, 3) != 0);
        clr_err = ($urandom_range(0, 49) == 0);
      end
    end
    clr_err = 1'b0;
    upd_ready = 1'b1;
    drive(4'b1111, 7'h7f, 5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
